// File: rtl/rect_fill_pkg.sv
// Shared types and screen defaults for the rectangle fill engine.
// Imported by rect_fill and rect_fill_colour.
package rect_fill_pkg;

    typedef enum logic [1:0] {
        SOLID   = 2'd0,
        XSTRIPE = 2'd1,
        YSTRIPE = 2'd2,
        CHECKER = 2'd3
    } fill_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;

endpackage

// File: rtl/rect_fill_colour.sv
// Pixel colour generator: maps (mode, base colour, x, y) to the plotted colour.
// Purely combinational; the top registers the result.
module rect_fill_colour
    import rect_fill_pkg::*;
#(
    parameter int XW = 8,
    parameter int YW = 7,
    parameter int CW = 3
) (
    input  fill_mode_e        mode,
    input  logic [CW-1:0]     colour,
    input  logic [XW-1:0]     x,
    input  logic [YW-1:0]     y,
    output logic [CW-1:0]     pix
);

    // Only the low coordinate bits feed the patterns.
    logic unused_coord_bits;
    assign unused_coord_bits = &{1'b0, x, y};

    always_comb begin
        pix = colour;
        case (mode)
            SOLID:   pix = colour;
            XSTRIPE: pix = x[CW-1:0];
            YSTRIPE: pix = y[CW-1:0];
            CHECKER: pix = (x[3] ^ y[3]) ? ~colour : colour;
            default: pix = colour;
        endcase
    end

endmodule

// File: rtl/rect_fill.sv
// Clipped rectangle fill engine: scans the rectangle column-major and
// plots one pixel per vga_plot/vga_ready handshake.
module rect_fill
    import rect_fill_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF,
    parameter int XW       = 8,
    parameter int YW       = 7,
    parameter int CW       = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] w,
    input  logic [YW-1:0] h,
    input  logic [CW-1:0] colour,
    input  logic [1:0]    mode,
    output logic          done,
    output logic [XW-1:0] vga_x,
    output logic [YW-1:0] vga_y,
    output logic [CW-1:0] vga_colour,
    output logic          vga_plot,
    input  logic          vga_ready
);

    localparam logic [XW:0] X_LIM = (XW+1)'(SCREEN_W);
    localparam logic [YW:0] Y_LIM = (YW+1)'(SCREEN_H);
    localparam logic [XW:0] X_MAX = (XW+1)'(SCREEN_W - 1);
    localparam logic [YW:0] Y_MAX = (YW+1)'(SCREEN_H - 1);

    state_e        state_q, state_d;
    logic [XW-1:0] x_q, x_d, x0_q, x0_d, x_end_q, x_end_d;
    logic [YW-1:0] y_q, y_d, y0_q, y0_d, y_end_q, y_end_d;
    logic [CW-1:0] colour_q, colour_d, vga_colour_q, vga_colour_d;
    fill_mode_e    mode_q, mode_d;
    logic          plot_q, plot_d, done_q, done_d;

    logic [XW:0]   x_sum;
    logic [YW:0]   y_sum;
    logic [XW-1:0] x_clip;
    logic [YW-1:0] y_clip;
    logic          empty;
    logic [CW-1:0] pix;

    // Extra bit on the sums keeps x0+w-1 from wrapping before the clip compare.
    always_comb begin
        x_sum  = {1'b0, x0} + {1'b0, w} - (XW+1)'(1);
        y_sum  = {1'b0, y0} + {1'b0, h} - (YW+1)'(1);
        x_clip = (x_sum > X_MAX) ? X_MAX[XW-1:0] : x_sum[XW-1:0];
        y_clip = (y_sum > Y_MAX) ? Y_MAX[YW-1:0] : y_sum[YW-1:0];
        empty  = (w == '0) || (h == '0) ||
                 ({1'b0, x0} >= X_LIM) || ({1'b0, y0} >= Y_LIM);
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        x_end_d  = x_end_q;
        y_end_d  = y_end_q;
        colour_d = colour_q;
        mode_d   = mode_q;
        plot_d   = plot_q;
        done_d   = done_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    x0_d     = x0;
                    y0_d     = y0;
                    x_end_d  = x_clip;
                    y_end_d  = y_clip;
                    colour_d = colour;
                    mode_d   = fill_mode_e'(mode);
                    if (empty) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FILL;
                        plot_d  = 1'b1;
                        x_d     = x0;
                        y_d     = y0;
                    end
                end
            end
            FILL: begin
                if (plot_q && vga_ready) begin
                    if (x_q == x_end_q && y_q == y_end_q) begin
                        state_d = DONE;
                        plot_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (y_q < y_end_q) begin
                        y_d = y_q + YW'(1);
                    end else begin
                        y_d = y0_q;
                        x_d = x_q + XW'(1);
                    end
                end
            end
            DONE: begin
                if (!start) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                plot_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    rect_fill_colour #(
        .XW(XW),
        .YW(YW),
        .CW(CW)
    ) u_colour (
        .mode  (mode_d),
        .colour(colour_d),
        .x     (x_d),
        .y     (y_d),
        .pix   (pix)
    );

    // Colour follows the next pixel only while plotting; otherwise it holds.
    assign vga_colour_d = plot_d ? pix : vga_colour_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            vga_colour_q <= '0;
            plot_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            vga_colour_q <= vga_colour_d;
            plot_q       <= plot_d;
            done_q       <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        x0_q     <= x0_d;
        y0_q     <= y0_d;
        x_end_q  <= x_end_d;
        y_end_q  <= y_end_d;
        colour_q <= colour_d;
        mode_q   <= mode_d;
    end

    assign done       = done_q;
    assign vga_x      = x_q;
    assign vga_y      = y_q;
    assign vga_colour = vga_colour_q;
    assign vga_plot   = plot_q;

endmodule
